// File: rtl/dram_pkg.sv
// dram_pkg: shared timing, field positions, command/state types and pin encoding for the DRAM controller
package dram_pkg;
  localparam int T_RP = 3;
  localparam int T_RCD = 3;
  localparam int T_WR = 3;
  localparam int T_TO = 15;
  localparam int T_MAX = (T_TO > T_RP && T_TO > T_RCD && T_TO > T_WR) ? T_TO :
                         (T_RP > T_RCD && T_RP > T_WR) ? T_RP : (T_RCD > T_WR) ? T_RCD : T_WR;
  localparam int CNT_W = $clog2(T_MAX) + 1;
  localparam int ROW_MSB = 22;
  localparam int ROW_LSB = 12;
  localparam int COL_MSB = 11;
  localparam int COL_LSB = 2;
  typedef enum logic [2:0] {CMD_NOP, CMD_PRE, CMD_ACT, CMD_RD, CMD_WR} dram_cmd_e;
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_Q, S_WAIT_WR
  } dram_state_e;
  // {RASn, CASn, WEn}; for CMD_WR the caller replaces WEn with ~wstrb
  function automatic logic [5:0] cmd2pins(dram_cmd_e c);
    return c == CMD_PRE ? 6'b01_0000 :
           c == CMD_ACT ? 6'b01_1111 :
           (c == CMD_RD || c == CMD_WR) ? 6'b10_1111 : 6'b11_1111;
  endfunction
endpackage

// File: rtl/dram_if.sv
// dram_if: single-word request/response bus between the bus slave wrapper and the DRAM controller
interface dram_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [31:0] req_addr;
  logic [3:0] req_wstrb;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_wait_cnt.sv
// dram_wait_cnt: loadable down-counter with zero flag shared by all controller waits
module dram_wait_cnt #(
  parameter int W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] val,
  output logic zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: open-row DRAM command sequencer turning single-word bus requests into PRE/ACT/READ/WRITE
module dram_ctrl
  import dram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dram_if.slave bus,
  output logic DRAM_CSn,
  output logic DRAM_RASn,
  output logic DRAM_CASn,
  output logic [3:0] DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic DRAM_valid
);
  dram_state_e st, st_n;
  dram_cmd_e cmd_n;
  logic ready, rsp_valid, rsp_err, rsp_n, err_n, acc, zero, ld, row_open;
  logic [31:0] rsp_rdata, wdata_q, wdata_c;
  logic [10:0] open_row, row_q, row_c;
  logic [9:0] col_q, col_c;
  logic [3:0] wstrb_q, wstrb_c;
  logic wr_q, wr_c, unused;
  logic [CNT_W-1:0] ld_val;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err = rsp_err;
  assign unused = ^{bus.req_addr[31:23], bus.req_addr[1:0]};
  assign acc = st == S_IDLE && ready && bus.req_valid;
  // In IDLE the next command is built straight from the request being accepted
  assign row_c = st == S_IDLE ? bus.req_addr[ROW_MSB:ROW_LSB] : row_q;
  assign col_c = st == S_IDLE ? bus.req_addr[COL_MSB:COL_LSB] : col_q;
  assign wr_c = st == S_IDLE ? bus.req_write : wr_q;
  assign wstrb_c = st == S_IDLE ? bus.req_wstrb : wstrb_q;
  assign wdata_c = st == S_IDLE ? bus.req_wdata : wdata_q;
  assign ld = st == S_PRE || st == S_ACT || st == S_RW;
  assign ld_val = st == S_PRE ? CNT_W'(T_RP - 1) : st == S_ACT ? CNT_W'(T_RCD - 1) :
                  wr_q ? CNT_W'(T_WR - 1) : CNT_W'(T_TO - 1);
  dram_wait_cnt #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .load(ld), .val(ld_val), .zero(zero));
  always_comb begin
    st_n = st;
    rsp_n = 1'b0;
    err_n = 1'b0;
    case (st)
      S_IDLE: if (acc) st_n = (row_open && row_c == open_row) ? S_RW : row_open ? S_PRE : S_ACT;
      S_PRE: st_n = S_WAIT_RP;
      S_WAIT_RP: if (zero) st_n = S_ACT;
      S_ACT: st_n = S_WAIT_RCD;
      S_WAIT_RCD: if (zero) st_n = S_RW;
      S_RW: st_n = wr_q ? S_WAIT_WR : S_WAIT_Q;
      S_WAIT_Q: if (DRAM_valid || zero) begin
        st_n = S_IDLE;
        rsp_n = 1'b1;
        err_n = !DRAM_valid;
      end
      S_WAIT_WR: if (zero) begin
        st_n = S_IDLE;
        rsp_n = 1'b1;
      end
      default: st_n = S_IDLE;
    endcase
    cmd_n = st_n == S_PRE ? CMD_PRE : st_n == S_ACT ? CMD_ACT :
            st_n == S_RW ? (wr_c ? CMD_WR : CMD_RD) : CMD_NOP;
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      wr_q <= bus.req_write;
      row_q <= bus.req_addr[ROW_MSB:ROW_LSB];
      col_q <= bus.req_addr[COL_MSB:COL_LSB];
      wstrb_q <= bus.req_wstrb;
      wdata_q <= bus.req_wdata;
    end
  end
  // Pins are registered from the next state so each command lasts exactly the cycle its state does
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      row_open <= 1'b0;
      open_row <= '0;
      ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      DRAM_CSn <= 1'b1;
      {DRAM_RASn, DRAM_CASn, DRAM_WEn} <= 6'h3F;
      DRAM_A <= '0;
      DRAM_D <= '0;
    end else begin
      st <= st_n;
      ready <= st_n == S_IDLE && !rsp_n;
      rsp_valid <= rsp_n;
      if (rsp_n) begin
        rsp_rdata <= (st == S_WAIT_Q && DRAM_valid) ? DRAM_Q : '0;
        rsp_err <= err_n;
      end
      DRAM_CSn <= 1'b0;
      {DRAM_RASn, DRAM_CASn, DRAM_WEn} <= cmd2pins(cmd_n);
      if (cmd_n == CMD_WR) DRAM_WEn <= ~wstrb_c;
      if (cmd_n == CMD_PRE) DRAM_A <= open_row;
      if (cmd_n == CMD_ACT) DRAM_A <= row_c;
      if (cmd_n == CMD_RD || cmd_n == CMD_WR) DRAM_A <= {1'b0, col_c};
      if (cmd_n == CMD_WR) DRAM_D <= wdata_c;
      if (cmd_n == CMD_PRE) row_open <= 1'b0;
      if (cmd_n == CMD_ACT) begin
        row_open <= 1'b1;
        open_row <= row_c;
      end
    end
  end
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed bench for dram_ctrl with a small behavioural DRAM responder
module tb_dram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dram_if bus ();
  logic csn, rasn, casn;
  logic [3:0] wen;
  logic [10:0] a;
  logic [31:0] d;
  logic [31:0] q = '0;
  logic qv = 1'b0;
  dram_ctrl u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .DRAM_CSn(csn), .DRAM_RASn(rasn), .DRAM_CASn(casn), .DRAM_WEn(wen),
    .DRAM_A(a), .DRAM_D(d), .DRAM_Q(q), .DRAM_valid(qv)
  );
  int checks = 0, failures = 0, cyc = 0, acc = 0, rsp_cnt = 0, got_off = 0;
  logic mute = 1'b0;
  logic [31:0] mem [int];
  logic [10:0] mrow = '0;
  int rd_cnt = 0, rd_idx = 0, m_idx = 0;
  logic [31:0] m_tmp, got_rdata;
  logic got_err;
  typedef struct {int cyc; logic [1:0] k; logic [10:0] a; logic [3:0] wen; logic [31:0] d;} ent_t;
  ent_t log_q [$];
  always @(posedge clk) cyc <= cyc + 1;
  // DRAM responder: read data appears three cycles after READ, writes honour per-byte WEn
  always @(posedge clk) begin
    qv <= 1'b0;
    if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) begin
        qv <= 1'b1;
        q <= mem.exists(rd_idx) ? mem[rd_idx] : 32'h0;
      end
    end
    if (!csn && !rasn && wen == 4'hF) mrow <= a;
    if (!csn && rasn && !casn) begin
      m_idx = int'(mrow) * 1024 + int'(a[9:0]);
      if (wen == 4'hF) begin
        if (!mute) begin
          rd_cnt <= 2;
          rd_idx <= m_idx;
        end
      end else begin
        m_tmp = mem.exists(m_idx) ? mem[m_idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (!wen[b]) m_tmp[8*b +: 8] = d[8*b +: 8];
        mem[m_idx] = m_tmp;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && !csn && !(rasn && casn))
      log_q.push_back('{cyc, !rasn ? (wen == 4'h0 ? 2'd0 : 2'd1) : (wen == 4'hF ? 2'd2 : 2'd3), a, wen, d});
    if (bus.rsp_valid) rsp_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // kind: 0=PRE 1=ACT 2=READ(WEn=F) 3=WRITE; off is the cycle relative to acceptance
  task automatic chk_cmd(input string tag, input int i, input logic [1:0] k, input logic [10:0] ea,
                         input logic [3:0] ew, input int off);
    logic [31:0] g;
    g = '1;
    if (i < log_q.size()) g = {8'(log_q[i].cyc - acc), log_q[i].wen, log_q[i].k, 7'd0, log_q[i].a};
    chk(tag, g, {8'(off), ew, k, 7'd0, ea});
  endtask
  task automatic start_req(input logic w, input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd);
    int n;
    log_q.delete();
    bus.req_write = w;
    bus.req_addr = ad;
    bus.req_wstrb = st;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(bus.req_ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic do_req(input logic w, input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd);
    int n;
    start_req(w, ad, st, wd);
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    got_off = cyc - acc;
    got_rdata = bus.rsp_rdata;
    got_err = bus.rsp_err;
  endtask
  task automatic chk_reset_pins(input string tag);
    chk({tag, "_pins"}, {25'd0, csn, rasn, casn, wen}, 32'h7F);
    chk({tag, "_a"}, 32'(a), 32'h0);
    chk({tag, "_d"}, d, 32'h0);
    chk({tag, "_bus"}, {29'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err}, 32'h0);
  endtask
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wstrb = '0;
    bus.req_wdata = '0;
    mem[32'h040 * 1024 + 2] = 32'hDEADBEEF;
    mem[32'h040 * 1024 + 3] = 32'hAABBCCDD;
    mem[32'h041 * 1024 + 2] = 32'h41410202;
    repeat (3) @(negedge clk);
    chk_reset_pins("rst");
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;
    do_req(1'b0, 32'h0004_0008, 4'h0, 32'h0);
    chk("t1_ncmd", 32'(log_q.size()), 32'd2);
    chk_cmd("t1_act", 0, 2'd1, 11'h040, 4'hF, 1);
    chk_cmd("t1_rd", 1, 2'd2, 11'h002, 4'hF, 5);
    chk("t1_off", 32'(got_off), 32'd9);
    chk("t1_data", got_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(got_err), 32'd0);
    do_req(1'b1, 32'h0004_000C, 4'b0101, 32'h1122_3344);
    chk("t2_ncmd", 32'(log_q.size()), 32'd1);
    chk_cmd("t2_wr", 0, 2'd3, 11'h003, 4'b1010, 1);
    chk("t2_d", log_q.size() > 0 ? log_q[0].d : 32'hX, 32'h1122_3344);
    chk("t2_off", 32'(got_off), 32'd5);
    chk("t2_err", 32'(got_err), 32'd0);
    do_req(1'b1, 32'h0004_000C, 4'h0, 32'hFFFF_FFFF);
    chk_cmd("t2z_wr", 0, 2'd2, 11'h003, 4'hF, 1);
    chk("t2z_off", 32'(got_off), 32'd5);
    chk("t2z_err", 32'(got_err), 32'd0);
    do_req(1'b0, 32'h0004_000C, 4'h0, 32'h0);
    chk_cmd("t2_rb_rd", 0, 2'd2, 11'h003, 4'hF, 1);
    chk("t2_rb_data", got_rdata, 32'hAA22_CC44);
    do_req(1'b0, 32'h0004_0008, 4'h0, 32'h0);
    chk("t3_ncmd", 32'(log_q.size()), 32'd1);
    chk_cmd("t3_rd", 0, 2'd2, 11'h002, 4'hF, 1);
    chk("t3_off", 32'(got_off), 32'd5);
    chk("t3_data", got_rdata, 32'hDEADBEEF);
    do_req(1'b0, 32'h0004_1008, 4'h0, 32'h0);
    chk("t4_ncmd", 32'(log_q.size()), 32'd3);
    chk_cmd("t4_pre", 0, 2'd0, 11'h040, 4'h0, 1);
    chk_cmd("t4_act", 1, 2'd1, 11'h041, 4'hF, 5);
    chk_cmd("t4_rd", 2, 2'd2, 11'h002, 4'hF, 9);
    chk("t4_off", 32'(got_off), 32'd13);
    chk("t4_data", got_rdata, 32'h4141_0202);
    mute = 1'b1;
    do_req(1'b0, 32'h0004_1014, 4'h0, 32'h0);
    mute = 1'b0;
    chk_cmd("t5_rd", 0, 2'd2, 11'h005, 4'hF, 1);
    chk("t5_off", 32'(got_off), 32'd17);
    chk("t5_err", 32'(got_err), 32'd1);
    chk("t5_data", got_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_req(1'b0, 32'h0004_0008, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    n = rsp_cnt;
    @(negedge clk);
    chk_reset_pins("t6");
    chk_cmd("t6_act", 0, 2'd1, 11'h040, 4'hF, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_rsp", 32'(rsp_cnt - n), 32'd0);
    do_req(1'b0, 32'h0004_0008, 4'h0, 32'h0);
    chk_cmd("t6_reopen", 0, 2'd1, 11'h040, 4'hF, 1);
    chk_cmd("t6_rd", 1, 2'd2, 11'h002, 4'hF, 5);
    chk("t6_data", got_rdata, 32'hDEADBEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
